// File: rtl/buffer_column_read_ctrl.sv
// Column read sequencer for the transposed interpolation buffer: walks the column
// mux select 1..NUM_COLS, one column per downstream handshake, then pulses done.
module buffer_column_read_ctrl #(
  parameter int NUM_COLS = 4,
  parameter int LOAD_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       ready,
  output logic [2:0] select,
  output logic       col_valid,
  output logic       col_last,
  output logic       busy,
  output logic       done,
  output logic       start_err
);

  typedef enum logic [1:0] {IDLE, WAIT, READ, FIN} state_t;

  localparam logic [2:0] LAST_COL  = 3'(NUM_COLS);
  localparam logic [3:0] WAIT_INIT = (LOAD_LAT == 0) ? 4'd0 : 4'(LOAD_LAT - 1);

  state_t     state_q, state_d;
  logic [2:0] col_q, col_d;
  logic [3:0] wait_q, wait_d;
  logic       start_err_d;
  logic [2:0] select_d;
  logic       col_valid_d, col_last_d, busy_d, done_d;

  // State, counters and all outputs are registered so no input reaches an output
  // combinationally; outputs are decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      col_q     <= 3'd0;
      wait_q    <= 4'd0;
      select    <= 3'd0;
      col_valid <= 1'b0;
      col_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      start_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      wait_q    <= wait_d;
      select    <= select_d;
      col_valid <= col_valid_d;
      col_last  <= col_last_d;
      busy      <= busy_d;
      done      <= done_d;
      start_err <= start_err_d;
    end
  end

  // Abort outranks everything; a start during WAIT/READ is flagged but never queued.
  // The wait counter is loaded with LOAD_LAT-1 so WAIT lasts exactly LOAD_LAT cycles.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    wait_d      = wait_q;
    start_err_d = 1'b0;
    if (abort) begin
      state_d = IDLE;
      col_d   = 3'd0;
      wait_d  = 4'd0;
    end else begin
      case (state_q)
        IDLE, FIN: begin
          col_d  = 3'd0;
          wait_d = 4'd0;
          if (start) begin
            if (LOAD_LAT == 0) begin
              state_d = READ;
              col_d   = 3'd1;
            end else begin
              state_d = WAIT;
              wait_d  = WAIT_INIT;
            end
          end else begin
            state_d = IDLE;
          end
        end
        WAIT: begin
          start_err_d = start;
          if (wait_q == 4'd0) begin
            state_d = READ;
            col_d   = 3'd1;
          end else begin
            wait_d = wait_q - 4'd1;
          end
        end
        READ: begin
          start_err_d = start;
          if (ready) begin
            if (col_q == LAST_COL) begin
              state_d = FIN;
              col_d   = 3'd0;
            end else begin
              col_d = col_q + 3'd1;
            end
          end
        end
        default: begin
          state_d = IDLE;
          col_d   = 3'd0;
          wait_d  = 4'd0;
        end
      endcase
    end
  end

  always_comb begin
    col_valid_d = (state_d == READ);
    select_d    = col_valid_d ? col_d : 3'd0;
    col_last_d  = col_valid_d && (col_d == LAST_COL);
    busy_d      = (state_d == WAIT) || (state_d == READ);
    done_d      = (state_d == FIN);
  end

endmodule

// File: tb/tb_buffer_column_read_ctrl.sv
// Bench for buffer_column_read_ctrl: directed timing checks plus a scoreboard of
// expected column selects popped at every accepted handshake.
module tb_buffer_column_read_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  logic       start_a, abort_a, ready_a;
  logic [2:0] select_a;
  logic       col_valid_a, col_last_a, busy_a, done_a, start_err_a;

  logic       start_b, abort_b, ready_b;
  logic [2:0] select_b;
  logic       col_valid_b, col_last_b, busy_b, done_b, start_err_b;

  int passed = 0;
  int total  = 0;
  int done_cnt_a = 0;
  int done_cnt_b = 0;
  int done_before;
  int exp_q_a[$];
  int exp_q_b[$];

  always #5 clk = ~clk;

  buffer_column_read_ctrl #(.NUM_COLS(4), .LOAD_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .ready(ready_a),
    .select(select_a), .col_valid(col_valid_a), .col_last(col_last_a),
    .busy(busy_a), .done(done_a), .start_err(start_err_a)
  );

  buffer_column_read_ctrl #(.NUM_COLS(7), .LOAD_LAT(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .ready(ready_b),
    .select(select_b), .col_valid(col_valid_b), .col_last(col_last_b),
    .busy(busy_b), .done(done_b), .start_err(start_err_b)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    else
      passed++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives instance A inputs; a start with no abort pushes the expected sweep.
  task automatic applyStimulus(input logic s, input logic a, input logic r,
                               input logic expect_sweep);
    start_a = s;
    abort_a = a;
    ready_a = r;
    if (expect_sweep)
      for (int c = 1; c <= 4; c++) exp_q_a.push_back(c);
  endtask

  // Scoreboard: each handshake (col_valid && ready) consumes one expected column.
  always @(negedge clk) begin
    if (col_valid_a && ready_a) begin
      if (exp_q_a.size() > 0) begin
        int e;
        e = exp_q_a.pop_front();
        checkOutput("sbA_select", 32'(select_a), 32'(e));
        checkOutput("sbA_col_last", 32'(col_last_a), 32'(e == 4));
      end else begin
        checkOutput("sbA_unexpected_col", 32'(select_a), 32'd0);
      end
    end
    if (col_valid_b && ready_b) begin
      if (exp_q_b.size() > 0) begin
        int e;
        e = exp_q_b.pop_front();
        checkOutput("sbB_select", 32'(select_b), 32'(e));
        checkOutput("sbB_col_last", 32'(col_last_b), 32'(e == 7));
      end else begin
        checkOutput("sbB_unexpected_col", 32'(select_b), 32'd0);
      end
    end
    if (done_a) done_cnt_a++;
    if (done_b) done_cnt_b++;
  end

  initial begin
    rst_n   = 1'b0;
    start_a = 1'b0; abort_a = 1'b0; ready_a = 1'b0;
    start_b = 1'b0; abort_b = 1'b0; ready_b = 1'b0;
    step();
    checkOutput("rst_select", 32'(select_a), 32'd0);
    checkOutput("rst_busy", 32'(busy_a), 32'd0);
    checkOutput("rst_col_valid", 32'(col_valid_a), 32'd0);
    checkOutput("rst_done", 32'(done_a), 32'd0);
    checkOutput("rst_start_err", 32'(start_err_a), 32'd0);
    rst_n = 1'b1;
    step();

    // Basic sweep, ready tied high
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    step();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("basic_t1_select", 32'(select_a), 32'd0);
    checkOutput("basic_t1_busy", 32'(busy_a), 32'd1);
    checkOutput("basic_t1_col_valid", 32'(col_valid_a), 32'd0);
    for (int c = 1; c <= 4; c++) begin
      step();
      checkOutput("basic_select", 32'(select_a), 32'(c));
      checkOutput("basic_col_last", 32'(col_last_a), 32'(c == 4));
      checkOutput("basic_busy", 32'(busy_a), 32'd1);
    end
    step();
    checkOutput("basic_done", 32'(done_a), 32'd1);
    checkOutput("basic_fin_busy", 32'(busy_a), 32'd0);
    checkOutput("basic_fin_select", 32'(select_a), 32'd0);
    step();
    checkOutput("basic_done_one_cycle", 32'(done_a), 32'd0);
    checkOutput("basic_drain", 32'(exp_q_a.size()), 32'd0);

    // Reset asserted mid-sweep takes effect without a clock edge
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    step();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    step();
    step();
    checkOutput("rstmid_pre_select", 32'(select_a), 32'd2);
    rst_n = 1'b0;
    #1;
    checkOutput("rstmid_select", 32'(select_a), 32'd0);
    checkOutput("rstmid_busy", 32'(busy_a), 32'd0);
    checkOutput("rstmid_col_valid", 32'(col_valid_a), 32'd0);
    exp_q_a.delete();
    step();
    rst_n = 1'b1;
    step();
    checkOutput("rstmid_idle_busy", 32'(busy_a), 32'd0);

    // Stall: ready low for three cycles on column 2
    done_before = done_cnt_a;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    step();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    step();
    checkOutput("stall_sel1", 32'(select_a), 32'd1);
    step();
    checkOutput("stall_sel2", 32'(select_a), 32'd2);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("stall_hold_select", 32'(select_a), 32'd2);
      checkOutput("stall_hold_valid", 32'(col_valid_a), 32'd1);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    step();
    checkOutput("stall_sel3", 32'(select_a), 32'd3);
    step();
    checkOutput("stall_sel4", 32'(select_a), 32'd4);
    step();
    checkOutput("stall_done", 32'(done_a), 32'd1);
    step();
    checkOutput("stall_single_done", 32'(done_cnt_a - done_before), 32'd1);
    checkOutput("stall_drain", 32'(exp_q_a.size()), 32'd0);

    // Overrun during READ, then back-to-back start held in FIN
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    step();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    step();
    step();
    step();
    checkOutput("ovr_sel3", 32'(select_a), 32'd3);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("ovr_start_err", 32'(start_err_a), 32'd1);
    checkOutput("ovr_sel4_unchanged", 32'(select_a), 32'd4);
    step();
    checkOutput("ovr_start_err_pulse", 32'(start_err_a), 32'd0);
    checkOutput("b2b_fin_done", 32'(done_a), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    step();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("b2b_wait_busy", 32'(busy_a), 32'd1);
    checkOutput("b2b_wait_select", 32'(select_a), 32'd0);
    checkOutput("b2b_no_start_err", 32'(start_err_a), 32'd0);
    step();
    checkOutput("b2b_first_select", 32'(select_a), 32'd1);
    for (int i = 0; i < 4; i++) step();
    checkOutput("b2b_done", 32'(done_a), 32'd1);
    step();
    checkOutput("b2b_drain", 32'(exp_q_a.size()), 32'd0);

    // Abort on column 2 with start asserted in the same cycle
    done_before = done_cnt_a;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    step();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    step();
    step();
    checkOutput("abort_pre_select", 32'(select_a), 32'd2);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    exp_q_a.delete();
    checkOutput("abort_select", 32'(select_a), 32'd0);
    checkOutput("abort_busy", 32'(busy_a), 32'd0);
    checkOutput("abort_col_valid", 32'(col_valid_a), 32'd0);
    checkOutput("abort_no_done", 32'(done_a), 32'd0);
    step();
    checkOutput("abort_stays_idle", 32'(busy_a), 32'd0);
    step();
    checkOutput("abort_done_count", 32'(done_cnt_a - done_before), 32'd0);

    // Seven columns, no load latency
    start_b = 1'b1;
    ready_b = 1'b1;
    for (int c = 1; c <= 7; c++) exp_q_b.push_back(c);
    step();
    start_b = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      checkOutput("p7_select", 32'(select_b), 32'(c));
      checkOutput("p7_col_last", 32'(col_last_b), 32'(c == 7));
      step();
    end
    checkOutput("p7_done", 32'(done_b), 32'd1);
    checkOutput("p7_fin_select", 32'(select_b), 32'd0);
    step();
    checkOutput("p7_drain", 32'(exp_q_b.size()), 32'd0);
    checkOutput("p7_done_count", 32'(done_cnt_b), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
